// File: rtl/jericalla_pkg.sv
// Shared definitions for the Jericalla instruction word and the sequencer FSM.
package jericalla_pkg;

  localparam int INSTR_W    = 17;
  localparam int DIRRAM_MSB = 16;
  localparam int DIRRAM_LSB = 13;
  localparam int OP_MSB     = 12;
  localparam int OP_LSB     = 9;
  localparam int DIR1_MSB   = 8;
  localparam int DIR1_LSB   = 5;
  localparam int DIR2_MSB   = 4;
  localparam int DIR2_LSB   = 1;
  localparam int EN_BIT     = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

  // A word that does not write RAM has no architectural effect.
  function automatic logic is_nop(input logic [INSTR_W-1:0] word);
    return !word[EN_BIT];
  endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Program store: DEPTH x INSTR_W register file, one synchronous write port
// and one asynchronous read port. Contents are not reset.
module seq_prog_mem #(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = 17
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [INSTR_W-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [INSTR_W-1:0]         rd_data
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/jericalla_sequencer.sv
// Issues a loaded program to the Jericalla datapath over valid/ready, with
// optional whole-program repeats. Define JERICALLA_SEQ_SKIP_NOP_EN to skip no-op slots.
module jericalla_sequencer #(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = 17,
  parameter int REP_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_en,
  input  logic [$clog2(DEPTH)-1:0]   load_addr,
  input  logic [INSTR_W-1:0]         load_data,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     length,
  input  logic [REP_W-1:0]           repeat_cnt,
  output logic [INSTR_W-1:0]         instr_out,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic                       busy,
  output logic                       done
);

  import jericalla_pkg::*;

  localparam int AW = $clog2(DEPTH);

  seq_state_t         state, state_nxt;
  logic [AW-1:0]      pc, pc_nxt;
  logic [REP_W-1:0]   rep, rep_nxt;
  logic [REP_W-1:0]   rep_max;
  logic [AW:0]        len;
  logic [INSTR_W-1:0] slot;
  logic               mem_we;
  logic               last_slot;
  logic               skip;
  logic               run_start;

  // Writes only land while idle so a running program is never disturbed.
  assign mem_we    = load_en && (state == IDLE);
  assign run_start = start && (state == IDLE);

  seq_prog_mem #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W)
  ) u_prog_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_addr (pc),
    .rd_data (slot)
  );

  assign last_slot = ({1'b0, pc} == (len - (AW+1)'(1)));

`ifdef JERICALLA_SEQ_SKIP_NOP_EN
  assign skip = (state == ISSUE) && is_nop(slot);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    rep_nxt     = rep;
    instr_valid = 1'b0;
    instr_out   = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          pc_nxt    = '0;
          rep_nxt   = '0;
          state_nxt = (length == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        busy = 1'b1;
        if (!skip) begin
          instr_valid = 1'b1;
          instr_out   = slot;
        end
        // A skipped slot advances exactly as an accepted one would.
        if (skip || instr_ready) begin
          if (!last_slot) begin
            pc_nxt = pc + AW'(1);
          end else if (rep == rep_max) begin
            state_nxt = DONE;
          end else begin
            pc_nxt  = '0;
            rep_nxt = rep + REP_W'(1);
          end
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= '0;
      rep   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      rep   <= rep_nxt;
    end
  end

  // Run parameters are captured once per start and held for the whole run.
  always_ff @(posedge clk) begin
    if (run_start) begin
      len     <= length;
      rep_max <= repeat_cnt;
    end
  end

endmodule
